fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, fetch address loaded on reset.
REQ-002 SHALL have parameter: EXC_VECTOR, 32'h0000_0180, redirect address on exception (FETCH_EXC_EN only).
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 stall_f  in  1  hazard stall; hold fetch-stage outputs.
REQ-006 br_taken  in  1 / br_target  in  32  branch redirect from decode.
REQ-007 jmp  in  1 / jmp_target  in  32  jump redirect from decode.
REQ-008 imem_req  out  1 / imem_addr  out  32  instruction memory request.
REQ-009 imem_ready  in  1 / imem_rdata  in  32  memory completion and data.
REQ-010 pc_f  out  32 / instr_f  out  32 / valid_f  out  1  fetch-stage result to IF/ID.
REQ-011 flush_d  out  1  combinational; high in any cycle a redirect is accepted.

Function
REQ-012 States: FETCH (request active), HOLD (word buffered while stalled), DISCARD (drop stale in-flight word).
REQ-013 FETCH: imem_req=1, imem_addr=pc; addr held stable until imem_ready.
REQ-014 FETCH, ready, no stall, no redirect: next edge pc_f<=pc, instr_f<=imem_rdata, valid_f<=1, pc<=pc+4; stay FETCH; 1 instr/cycle at ready=1.
REQ-015 FETCH, ready, stall_f: word+pc go to one-entry buffer, pc<=pc+4, -> HOLD; outputs unchanged.
REQ-016 FETCH, no ready, stall_f: outputs held, request continues.
REQ-017 HOLD: imem_req=0; when stall_f=0, buffer -> outputs, valid_f<=1, -> FETCH.
REQ-018 Redirect priority: exception > br_taken > jmp; honoured regardless of stall_f.
REQ-019 Redirect: pc<=target with bits[1:0] forced 0, valid_f<=0 next edge, buffer cleared.
REQ-020 Redirect in FETCH without ready -> DISCARD; redirect with ready, or in HOLD/DISCARD -> FETCH (DISCARD: drop data, keep new target).
REQ-021 DISCARD: imem_req=0, word on imem_ready dropped, then -> FETCH with redirected pc.
REQ-022 pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.

Reset
REQ-023 rst asserted: immediately state=FETCH, pc=RESET_PC, pc_f=0, instr_f=0, valid_f=0, buffer empty, epc=0.
REQ-024 rst mid-transaction abandons the in-flight request; first word after release is fetched from RESET_PC.
REQ-025 First imem_req in first cycle after rst deasserts.

Configuration
REQ-026 Macro FETCH_EXC_EN defined: ports exc_req in 1 and epc out 32 exist; exc_req redirects to EXC_VECTOR, epc<=pc_f of oldest valid word (pc if valid_f=0).
REQ-027 FETCH_EXC_EN undefined: exc_req/epc ports absent, no exception logic synthesized.

Structure
REQ-028 Package fetch_pkg SHALL hold state enum, RESET_PC/EXC_VECTOR defaults, PC increment constant 4.
REQ-029 One-entry buffer SHALL be sub-module fetch_skid_buf (load, unload, clear, pc+word storage).

Verification
REQ-030 Reset release, ready=1: pc_f sequence 0,4,8,C on consecutive cycles, valid_f=1 from cycle 2.
REQ-031 ready=1, stall_f high 3 cycles at pc 8: pc_f/instr_f held; after release pc_f=C then 10, none lost or duplicated.
REQ-032 br_taken target 32'h40, ready delayed 2 cycles: flush_d=1, DISCARD, stale word dropped, next valid pc_f=32'h40.
REQ-033 br_taken and jmp same cycle (targets 40, 80): pc_f next valid =40; target 32'h43 fetched as 32'h40.
REQ-034 pc set to 32'hFFFF_FFFC by jmp: next pc_f 32'h0; rst pulse mid-wait: pc_f=0, valid_f=0 immediately.
REQ-035 FETCH_EXC_EN: exc_req at pc_f=32'h20 -> next fetch 32'h180, epc=32'h20.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch controller.
// Reset PC / exception vector defaults, the PC increment, the FSM state
// encoding and the buffered-word record used by fetch_skid_buf.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;
    localparam logic [31:0] PC_INCR            = 32'd4;

    // FETCH: request active; HOLD: word parked while stalled;
    // DISCARD: waiting to drop a stale in-flight word after a redirect.
    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    // One fetched word together with the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } buf_entry_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response bundle.
// master = fetch controller (drives req/addr), slave = memory (drives ready/rdata).
interface fetch_if;

    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry buffer holding a fetched word and its pc while
// the fetch stage is stalled. Priority: clear > load > unload.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       unload,
    input  logic       clear,
    input  buf_entry_t din,
    output logic       valid,
    output buf_entry_t dout
);

    logic       valid_q, valid_d;
    buf_entry_t data_q, data_d;

    // Next-state for occupancy and stored entry.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = din;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    // Storage registers; a single entry is cheap enough to reset entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller with branch/jump redirect,
// stall handling through a one-entry skid buffer, and stale-word discard.
// Optional exception redirect and EPC capture when FETCH_EXC_EN is defined.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
`ifdef FETCH_EXC_EN
   ,parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
`endif
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
`ifdef FETCH_EXC_EN
    input  logic        exc_req,
    output logic [31:0] epc,
`endif
    fetch_if.master     imem,
    output logic [31:0] pc_f,
    output logic [31:0] instr_f,
    output logic        valid_f,
    output logic        flush_d
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_f_q, pc_f_d;
    logic [31:0]  instr_f_q, instr_f_d;
    logic         valid_f_q, valid_f_d;

    logic         redirect;
    logic [31:0]  redirect_pc;

    logic         buf_load, buf_unload, buf_clear, buf_valid;
    buf_entry_t   buf_in, buf_out;

`ifdef FETCH_EXC_EN
    logic [31:0]  epc_q, epc_d;
`endif

    fetch_skid_buf u_skid_buf (
        .clk    (clk),
        .rst    (rst),
        .load   (buf_load),
        .unload (buf_unload),
        .clear  (buf_clear),
        .din    (buf_in),
        .valid  (buf_valid),
        .dout   (buf_out)
    );

    // Redirect select: exception > branch > jump, target word aligned.
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = pc_q;
`ifdef FETCH_EXC_EN
        if (exc_req) begin
            redirect    = 1'b1;
            redirect_pc = align_pc(EXC_VECTOR);
        end else
`endif
        if (br_taken) begin
            redirect    = 1'b1;
            redirect_pc = align_pc(br_target);
        end else if (jmp) begin
            redirect    = 1'b1;
            redirect_pc = align_pc(jmp_target);
        end
    end

    // FSM next-state and fetch-stage datapath.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_f_d     = pc_f_q;
        instr_f_d  = instr_f_q;
        valid_f_d  = valid_f_q;
        buf_load   = 1'b0;
        buf_unload = 1'b0;
        buf_clear  = 1'b0;
        buf_in     = '{pc: pc_q, word: imem.rdata};

        if (redirect) begin
            // A redirect wins over stall; an unfinished request leaves a
            // stale word in flight that DISCARD must swallow.
            pc_d      = redirect_pc;
            valid_f_d = 1'b0;
            buf_clear = 1'b1;
            state_d   = (state_q == ST_FETCH && !imem.ready) ? ST_DISCARD : ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem.ready) begin
                        pc_d = pc_q + PC_INCR;
                        if (stall_f) begin
                            buf_load = 1'b1;
                            state_d  = ST_HOLD;
                        end else begin
                            pc_f_d    = pc_q;
                            instr_f_d = imem.rdata;
                            valid_f_d = 1'b1;
                        end
                    end else if (!stall_f) begin
                        // Decode consumed the last word and nothing new arrived.
                        valid_f_d = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall_f) begin
                        if (buf_valid) begin
                            pc_f_d    = buf_out.pc;
                            instr_f_d = buf_out.word;
                            valid_f_d = 1'b1;
                        end
                        buf_unload = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    if (imem.ready) begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

`ifdef FETCH_EXC_EN
    // EPC capture: oldest valid word is pc_f, then the buffer, else the pc.
    always_comb begin
        epc_d = epc_q;
        if (exc_req) begin
            if (valid_f_q)      epc_d = pc_f_q;
            else if (buf_valid) epc_d = buf_out.pc;
            else                epc_d = pc_q;
        end
    end
`endif

    // State, pc and fetch-stage registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            pc_f_q    <= '0;
            instr_f_q <= '0;
            valid_f_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_f_q    <= pc_f_d;
            instr_f_q <= instr_f_d;
            valid_f_q <= valid_f_d;
        end
    end

`ifdef FETCH_EXC_EN
    // Exception PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) epc_q <= '0;
        else     epc_q <= epc_d;
    end
    assign epc = epc_q;
`endif

    // Request is suppressed while reset is held so the first request lands
    // in the first cycle after release.
    assign imem.req  = (state_q == ST_FETCH) && !rst;
    assign imem.addr = pc_q;
    assign pc_f      = pc_f_q;
    assign instr_f   = instr_f_q;
    assign valid_f   = valid_f_q;
    assign flush_d   = redirect;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table-driven directed bench for fetch_ctrl plus hand-written
// reset-mid-wait and (with FETCH_EXC_EN) exception sequences.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_f;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        ready;
    logic [31:0] pc_f;
    logic [31:0] instr_f;
    logic        valid_f;
    logic        flush_d;
`ifdef FETCH_EXC_EN
    logic        exc_req;
    logic [31:0] epc;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_if imem_bus ();

    // Memory model: word content is a fixed function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign imem_bus.ready = ready;
    assign imem_bus.rdata = mem_word(imem_bus.addr);

    fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .stall_f    (stall_f),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp        (jmp),
        .jmp_target (jmp_target),
`ifdef FETCH_EXC_EN
        .exc_req    (exc_req),
        .epc        (epc),
`endif
        .imem       (imem_bus),
        .pc_f       (pc_f),
        .instr_f    (instr_f),
        .valid_f    (valid_f),
        .flush_d    (flush_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] br_tgt;
        logic        jp;
        logic [31:0] jp_tgt;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_flush;
        logic [31:0] e_pc_f;
        logic        e_valid;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic stall, input logic br, input logic [31:0] br_tgt,
                                input logic jp, input logic [31:0] jp_tgt, input logic rdy,
                                input logic e_req, input logic [31:0] e_addr, input logic e_flush,
                                input logic [31:0] e_pc_f, input logic e_valid);
        vec_t v;
        v.stall = stall; v.br = br; v.br_tgt = br_tgt; v.jp = jp; v.jp_tgt = jp_tgt;
        v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_flush = e_flush;
        v.e_pc_f = e_pc_f; v.e_valid = e_valid;
        return v;
    endfunction

    initial begin
        // Columns: stall br br_tgt jmp jmp_tgt ready | req addr flush pc_f valid_f
        // Outputs are those seen in the cycle the inputs are applied.
        vq.push_back(mk(0,0,0,0,0,1, 1,32'h00,0,32'h00,0));              // 0 first req after reset
        vq.push_back(mk(0,0,0,0,0,1, 1,32'h04,0,32'h00,1));              // 1
        vq.push_back(mk(0,0,0,0,0,1, 1,32'h08,0,32'h04,1));              // 2
        vq.push_back(mk(1,0,0,0,0,1, 1,32'h0C,0,32'h08,1));              // 3 stall, word C buffered
        vq.push_back(mk(1,0,0,0,0,1, 0,32'h10,0,32'h08,1));              // 4 HOLD
        vq.push_back(mk(1,0,0,0,0,1, 0,32'h10,0,32'h08,1));              // 5 HOLD
        vq.push_back(mk(0,0,0,0,0,1, 0,32'h10,0,32'h08,1));              // 6 release -> C
        vq.push_back(mk(0,0,0,0,0,1, 1,32'h10,0,32'h0C,1));              // 7
        vq.push_back(mk(0,0,0,0,0,0, 1,32'h14,0,32'h10,1));              // 8 no ready
        vq.push_back(mk(1,0,0,0,0,0, 1,32'h14,0,32'h10,0));              // 9 no ready, stall
        vq.push_back(mk(0,0,0,0,0,1, 1,32'h14,0,32'h10,0));              // 10
        vq.push_back(mk(0,1,32'h40,0,0,0, 1,32'h18,1,32'h14,1));         // 11 branch, no ready
        vq.push_back(mk(0,0,0,0,0,0, 0,32'h40,0,32'h14,0));              // 12 DISCARD
        vq.push_back(mk(0,0,0,0,0,1, 0,32'h40,0,32'h14,0));              // 13 stale word arrives
        vq.push_back(mk(0,0,0,0,0,1, 1,32'h40,0,32'h14,0));              // 14 fetch 40
        vq.push_back(mk(0,1,32'h40,1,32'h80,1, 1,32'h44,1,32'h40,1));    // 15 br+jmp together
        vq.push_back(mk(0,0,0,0,0,1, 1,32'h40,0,32'h40,0));              // 16 branch won
        vq.push_back(mk(0,1,32'h43,0,0,1, 1,32'h44,1,32'h40,1));         // 17 unaligned target
        vq.push_back(mk(0,0,0,0,0,1, 1,32'h40,0,32'h40,0));              // 18 aligned to 40
        vq.push_back(mk(1,0,0,1,32'hFFFF_FFFC,1, 1,32'h44,1,32'h40,1));  // 19 jmp under stall
        vq.push_back(mk(0,0,0,0,0,1, 1,32'hFFFF_FFFC,0,32'h40,0));       // 20
        vq.push_back(mk(0,0,0,0,0,1, 1,32'h00,0,32'hFFFF_FFFC,1));       // 21 pc wrapped
        vq.push_back(mk(0,0,0,0,0,0, 1,32'h04,0,32'h00,1));              // 22
        vq.push_back(mk(1,0,0,0,0,1, 1,32'h04,0,32'h00,0));              // 23 word 4 buffered
        vq.push_back(mk(1,1,32'h100,0,0,0, 0,32'h08,1,32'h00,0));        // 24 branch in HOLD
        vq.push_back(mk(0,0,0,0,0,1, 1,32'h100,0,32'h00,0));             // 25 buffer dropped
        vq.push_back(mk(0,0,0,0,0,1, 1,32'h104,0,32'h100,1));            // 26
    end

    initial begin
        bit found;
        rst = 1'b1; stall_f = 1'b0; br_taken = 1'b0; br_target = '0;
        jmp = 1'b0; jmp_target = '0; ready = 1'b0;
`ifdef FETCH_EXC_EN
        exc_req = 1'b0;
`endif
        #2;
        check("reset pc_f",    pc_f,    32'h0);
        check("reset instr_f", instr_f, 32'h0);
        check("reset valid_f", {31'd0, valid_f},  32'd0);
        check("reset req",     {31'd0, imem_bus.req}, 32'd0);
        check("reset addr",    imem_bus.addr, 32'h0);
        @(negedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b0;
            stall_f    = vq[i].stall;
            br_taken   = vq[i].br;
            br_target  = vq[i].br_tgt;
            jmp        = vq[i].jp;
            jmp_target = vq[i].jp_tgt;
            ready      = vq[i].rdy;
            #1;
            check($sformatf("row%0d req", i),   {31'd0, imem_bus.req}, {31'd0, vq[i].e_req});
            check($sformatf("row%0d addr", i),  imem_bus.addr, vq[i].e_addr);
            check($sformatf("row%0d flush", i), {31'd0, flush_d}, {31'd0, vq[i].e_flush});
            check($sformatf("row%0d pc_f", i),  pc_f, vq[i].e_pc_f);
            check($sformatf("row%0d valid", i), {31'd0, valid_f}, {31'd0, vq[i].e_valid});
            if (vq[i].e_valid)
                check($sformatf("row%0d instr", i), instr_f, mem_word(vq[i].e_pc_f));
        end

        // Reset pulse while a request is waiting for memory.
        @(negedge clk);
        stall_f = 1'b0; br_taken = 1'b0; jmp = 1'b0; ready = 1'b0;
        #1;
        check("wait addr", imem_bus.addr, 32'h108);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst pc_f",  pc_f, 32'h0);
        check("async rst valid", {31'd0, valid_f}, 32'd0);
        check("async rst req",   {31'd0, imem_bus.req}, 32'd0);
        @(negedge clk);
        rst = 1'b0; ready = 1'b1;
        #1;
        check("post rst req",  {31'd0, imem_bus.req}, 32'd1);
        check("post rst addr", imem_bus.addr, 32'h0);
        @(negedge clk);
        #1;
        check("post rst pc_f",  pc_f, 32'h0);
        check("post rst valid", {31'd0, valid_f}, 32'd1);
        check("post rst instr", instr_f, mem_word(32'h0));

`ifdef FETCH_EXC_EN
        // Exception while pc_f = 0x20.
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (pc_f == 32'h20 && valid_f) found = 1'b1;
            else begin @(negedge clk); #1; end
        end
        check("exc reach pc_f 20", {31'd0, found}, 32'd1);
        exc_req = 1'b1;
        #1;
        check("exc flush", {31'd0, flush_d}, 32'd1);
        @(negedge clk);
        exc_req = 1'b0;
        #1;
        check("exc epc",   epc, 32'h20);
        check("exc addr",  imem_bus.addr, 32'h180);
        check("exc valid", {31'd0, valid_f}, 32'd0);
        @(negedge clk);
        #1;
        check("exc pc_f", pc_f, 32'h180);
`else
        found = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
